// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: state encoding,
// default bus widths and the all-ones read strobe.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Watchdog for one memory transaction: cleared at grant, counts BUSY cycles
// without mem_ready, and flags expiry on the cycle the count reaches TIMEOUT.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Expiry is seen while counting the TIMEOUT-th stalled cycle, so the
    // transaction is closed after exactly TIMEOUT BUSY cycles.
    assign expire = run && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store.
// Define MEM_TIMEOUT_EN to add the watchdog that force-completes stalled accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    // state     | meaning
    // ST_IDLE   | no access in flight; arbitrate masked requests, data first
    // ST_BUSY_I | fetch on the memory bus, waiting for mem_ready
    // ST_BUSY_D | load/store on the memory bus, waiting for mem_ready

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ONES = '1;

    logic [1:0] state;
    logic       d_eff;
    logic       i_eff;
    logic       grant;
    logic       busy;
    logic       expire;
    logic       finish;

    // A requester still holding req during its done cycle must not be re-granted.
    assign d_eff  = d_req & ~d_done;
    assign i_eff  = i_req & ~i_done;
    assign busy   = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign grant  = (state == ST_IDLE) && (d_eff || i_eff);
    assign finish = busy && (mem_ready || expire);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (grant),
        .run    (busy & ~mem_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (expire) begin
            err <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (d_eff) begin
                    state     <= ST_BUSY_D;
                    mem_req   <= 1'b1;
                    mem_we    <= d_we;
                    mem_be    <= d_we ? d_be : BE_ONES;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else if (i_eff) begin
                    state    <= ST_BUSY_I;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_be   <= BE_ONES;
                    mem_addr <= i_addr;
                end
            end else if (finish) begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
                // A watchdog completion returns zero instead of bus data.
                if (state == ST_BUSY_I) begin
                    i_done  <= 1'b1;
                    i_rdata <= mem_ready ? mem_rdata : '0;
                end else begin
                    d_done <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_ready ? mem_rdata : '0;
                    end
                end
            end else if (!busy) begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected memory
// grants and done events, plus a behavioural memory with programmable latency.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_wdata;
    logic          i_done, d_done;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_req, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          err;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t done_q[$];
    txn_t cur;
    txn_t dn;

    int checks = 0;
    int errors = 0;

    int ready_delay = 0;
    int wait_cnt    = 0;
    bit mem_stall   = 0;
    bit stray_ready = 0;
    bit exp_timeout = 0;
    logic mem_req_q = 1'b0;
    logic [DW-1:0] exp_d_rdata = '0;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] got_rd;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h0000_0010) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model and scoreboard monitor, both on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_req_q = 1'b0;
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (mem_req && !mem_req_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected mem_req addr=%h we=%b", mem_addr, mem_we);
                end else begin
                    cur = exp_q.pop_front();
                    done_q.push_back(cur);
                    if (mem_addr !== cur.addr || mem_we !== cur.we || mem_be !== cur.be ||
                        (cur.we && mem_wdata !== cur.wdata)) begin
                        errors++;
                        $display("FAIL grant: got addr=%h we=%b be=%h wdata=%h want addr=%h we=%b be=%h wdata=%h",
                                 mem_addr, mem_we, mem_be, mem_wdata, cur.addr, cur.we, cur.be, cur.wdata);
                    end
                end
            end else if (mem_req && mem_req_q) begin
                checks++;
                if (mem_addr !== cur.addr || mem_we !== cur.we || mem_be !== cur.be ||
                    (cur.we && mem_wdata !== cur.wdata)) begin
                    errors++;
                    $display("FAIL hold: got addr=%h we=%b be=%h wdata=%h want addr=%h we=%b be=%h wdata=%h",
                             mem_addr, mem_we, mem_be, mem_wdata, cur.addr, cur.we, cur.be, cur.wdata);
                end
            end

            if (i_done || d_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected i_done=%b d_done=%b", i_done, d_done);
                end else begin
                    dn = done_q.pop_front();
                    if (dn.we) exp_rd = exp_d_rdata;
                    else if (exp_timeout) exp_rd = '0;
                    else exp_rd = mem_val(dn.addr);
                    got_rd = dn.is_d ? d_rdata : i_rdata;
                    if ((i_done && d_done) || d_done !== dn.is_d || got_rd !== exp_rd) begin
                        errors++;
                        $display("FAIL done: got i_done=%b d_done=%b rdata=%h want owner_d=%b rdata=%h",
                                 i_done, d_done, got_rd, dn.is_d, exp_rd);
                    end
                    if (dn.is_d && !dn.we) exp_d_rdata = exp_rd;
                end
            end

            if (!mem_req) begin
                mem_ready = stray_ready;
                mem_rdata = $urandom;
                wait_cnt  = 0;
            end else if (mem_ready || mem_stall) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end else if (wait_cnt >= ready_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val(mem_addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
                mem_rdata = $urandom;
            end
            mem_req_q = mem_req;
        end
    end

    function automatic txn_t mk(input logic is_d, input logic we, input logic [BW-1:0] be,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        txn_t t;
        t.is_d = is_d; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic wait_done(input bit is_d, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_done : i_done) && n < budget);
        if (!(is_d ? d_done : i_done)) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no %s done within %0d cycles", is_d ? "d" : "i", budget);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, err} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero i_done=%b i_rdata=%h d_done=%b d_rdata=%h mem_req=%b mem_we=%b mem_be=%h mem_addr=%h mem_wdata=%h err=%b, want all 0",
                     name, i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_fetch();
        int n;
        ready_delay = 0;
        @(negedge clk);
        exp_q.push_back(mk(1'b0, 1'b0, BE_ALL, 32'h0000_0010, '0));
        i_addr = 32'h0000_0010; i_req = 1'b1;
        wait_done(1'b0, 20, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL fetch_latency: got done at negedge %0d want 2 (3rd cycle of request)", n);
        end
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (i_done !== 1'b0 || i_rdata !== 32'h0000_0013) begin
            errors++;
            $display("FAIL fetch_pulse: got i_done=%b i_rdata=%h want 0 and 00000013", i_done, i_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b0, BE_ALL, 32'h0000_0100, '0));
        exp_q.push_back(mk(1'b0, 1'b0, BE_ALL, 32'h0000_0020, '0));
        d_addr = 32'h0000_0100; d_we = 1'b0; d_be = 4'h0; d_req = 1'b1;
        i_addr = 32'h0000_0020; i_req = 1'b1;
        wait_done(1'b1, 20, n);
        // d_req stays high through the d_done cycle
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0020 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL simul_fetch_next: got mem_req=%b addr=%h we=%b want 1 00000020 0 one cycle after d_done",
                     mem_req, mem_addr, mem_we);
        end
        wait_done(1'b0, 20, n);
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        int n;
        int busy_cnt;
        int dones;
        logic [DW-1:0] d_before;
        ready_delay = 5;
        d_before = exp_d_rdata;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h0000_0204, 32'hDEAD_BEEF));
        d_addr = 32'h0000_0204; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        busy_cnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_req) busy_cnt++;
        end while (!d_done && n < 30);
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if (busy_cnt !== 6) begin
            errors++;
            $display("FAIL store_busy_cycles: got %0d want 6", busy_cnt);
        end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_done) dones++;
        end
        checks++;
        if (dones !== 0 || d_rdata !== d_before) begin
            errors++;
            $display("FAIL store_after: got extra d_done=%0d d_rdata=%h want 0 and %h", dones, d_rdata, d_before);
        end
        ready_delay = 0;
    endtask

    task automatic test_back_to_back();
        int rise_at[3];
        int rises;
        int dones;
        logic prev;
        @(negedge clk);
        repeat (3) exp_q.push_back(mk(1'b0, 1'b0, BE_ALL, 32'h0000_0040, '0));
        i_addr = 32'h0000_0040; i_req = 1'b1;
        rises = 0; dones = 0; prev = mem_req;
        for (int c = 0; c < 40 && dones < 3; c++) begin
            @(negedge clk);
            if (mem_req && !prev && rises < 3) begin
                rise_at[rises] = c;
                rises++;
            end
            prev = mem_req;
            if (i_done) dones++;
        end
        i_req = 1'b0;
        checks++;
        if (rises !== 3 || dones !== 3) begin
            errors++;
            $display("FAIL b2b_count: got rises=%0d dones=%0d want 3 3", rises, dones);
        end else if (rise_at[1] - rise_at[0] !== 3 || rise_at[2] - rise_at[1] !== 3) begin
            checks++;
            errors++;
            $display("FAIL b2b_period: got %0d %0d want 3 3", rise_at[1] - rise_at[0], rise_at[2] - rise_at[1]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_ready();
        stray_ready = 1'b1;
        repeat (2) @(negedge clk);
        stray_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (i_done !== 1'b0 || d_done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got i_done=%b d_done=%b mem_req=%b want 0 0 0", i_done, d_done, mem_req);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int dones;
        mem_stall = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b0, BE_ALL, 32'h0000_0300, '0));
        d_addr = 32'h0000_0300; d_we = 1'b0; d_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_busy");
        exp_q.delete();
        done_q.delete();
        exp_d_rdata = '0;
        d_req = 1'b0;
        mem_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d d_done pulses want 0", dones);
        end
        exp_q.push_back(mk(1'b0, 1'b0, BE_ALL, 32'h0000_0010, '0));
        i_addr = 32'h0000_0010; i_req = 1'b1;
        wait_done(1'b0, 20, n);
        i_req = 1'b0;
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL reset_mid_refetch: got latency %0d want 2", n);
        end
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int busy_cnt;
        mem_stall   = 1'b1;
        exp_timeout = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk(1'b0, 1'b0, BE_ALL, 32'h0000_0050, '0));
        i_addr = 32'h0000_0050; i_req = 1'b1;
        busy_cnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_req) busy_cnt++;
        end while (!i_done && n < 40);
        i_req = 1'b0;
        checks++;
        if (busy_cnt !== 8 || err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got busy=%0d err=%b mem_req=%b want 8 1 0", busy_cnt, err, mem_req);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b want 1", err);
        end
        mem_stall   = 1'b0;
        exp_timeout = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_back_to_back();
        test_idle_ready();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d grants and %0d dones outstanding want 0 0",
                     exp_q.size(), done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Sequences one memory transaction at a time with a small FSM and registered memory-side outputs.
- Returns read data and a one-cycle done pulse to the requester that owns the transaction.
- Sits between pc_reg/instr fetch, the datapath's Rd_mem_data/Wr_mem_data/ALU_result path, and the memory macro; replaces the separate ROM/RAM ports when the core moves to a unified memory.

Parameters:
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide
- TIMEOUT, 64, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  ADDR_W  fetch address (pc_out)
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  load/store request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte strobes
- d_addr  in  ADDR_W  data address (ALU_result)
- d_wdata  in  DATA_W  store data (Wr_mem_data)
- d_done  out  1  one-cycle pulse: load/store complete
- d_rdata  out  DATA_W  load data (to Rd_mem_data)
- mem_req  out  1  memory transaction active; held until mem_ready
- mem_we  out  1  write enable
- mem_be  out  DATA_W/8  byte strobes; all ones for reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory completion; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0, including i_rdata, d_rdata, mem_* and err; the watchdog counter is cleared.
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE:
  - Arbitration uses masked requests: d_eff = d_req & ~d_done and i_eff = i_req & ~i_done. This prevents re-granting a requester in the same cycle it receives its done.
  - d_eff has fixed priority over i_eff, because the load/store belongs to the older instruction.
  - d_eff -> BUSY_D. Register mem_req=1 and mem_we=d_we. Register mem_be = d_we ? d_be : all ones. Register d_addr into mem_addr and d_wdata into mem_wdata.
  - Else i_eff -> BUSY_I. Register mem_req=1, mem_we=0, mem_be = all ones, mem_addr = i_addr.
  - Neither -> stay in IDLE with mem_req=0.
- BUSY_x:
  - Hold all mem_* outputs stable until mem_ready.
  - On mem_ready: mem_req<=0 and state<=IDLE. The owner's done pulses high for exactly the next cycle.
  - For a fetch or a load, the owner's rdata<=mem_rdata. For a store, d_rdata holds its previous value.
- Latency:
  - Grant in IDLE at cycle N gives mem_req high from N+1.
  - mem_ready at cycle M gives done at M+1. The FSM can re-arbitrate at M+1, so the next mem_req rises at M+2.
  - Best case is mem_ready in the same cycle mem_req rises, giving a 3-cycle request-to-done.
- Mid-transaction requests: ignored until IDLE. A requester dropping req mid-transaction does not abort it; done still pulses.
- Simultaneous i_req and d_req: data is served first and fetch is served next. Fetch starvation is bounded by the core, which issues at most one data access per instruction.
- mem_ready seen in IDLE: ignored.
- i_rdata and d_rdata hold their last captured value between transactions.
- Reset asserted mid-transaction: abort immediately to reset values. No done is issued for the aborted transaction.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A counter, clog2(TIMEOUT+1) bits, clears on entry to BUSY_x and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT, the transaction is force-completed: owner done pulses, rdata<=0, err<=1 (sticky until reset), state<=IDLE.
- Without the macro: no counter exists, err is constant 0, and BUSY waits on mem_ready indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding ST_IDLE=2'd0, ST_BUSY_I=2'd1, ST_BUSY_D=2'd2
  - the default ADDR_W and DATA_W
  - the BE_ALL constant (all-ones strobe)
- One natural sub-module: mem_timeout_cnt (the watchdog counter with start/clear/expire), instantiated only under MEM_TIMEOUT_EN.
- The arbiter and FSM stay in the top module.

Test Plan:
- Fetch only, with i_addr=0x0000_0010 and mem_ready in the same cycle as mem_req, memory returning 0x0000_0013:
  - mem_addr must be 0x10 with mem_we=0 and mem_be=4'hF.
  - i_done must pulse 1 cycle with i_rdata=0x0000_0013, 3 cycles after i_req.
- i_req and d_req both rise in the same cycle, with d_addr=0x100 and d_we=0:
  - The data transaction is granted first.
  - The fetch follows; its mem_req rises 1 cycle after d_done.
  - No double grant of data occurs while d_req is still high in the d_done cycle.
- Store with d_addr=0x204, d_be=4'b0011, d_wdata=0xDEAD_BEEF, mem_ready delayed 5 cycles:
  - mem_* outputs are stable for all 6 BUSY cycles.
  - d_done pulses once; d_rdata is unchanged.
- Back-to-back fetches with i_req held continuously: the arbiter re-grants only after i_done deasserts, giving a mem_req period of 3 cycles.
- rst_n asserted during BUSY_D: all outputs go to 0 asynchronously and no d_done is issued; after release, a new i_req is served normally.
- With MEM_TIMEOUT_EN, TIMEOUT=8 and mem_ready never asserted: i_done pulses after 8 BUSY cycles with i_rdata=0, err=1 sticky, and the FSM returns to IDLE.
